zf_mm_stream_initiator: RTL and testbench

- Initiator/consumer end of the 4x4-by-4x2 matrix-multiplier start/done interface.
- Receives 16-bit fixed-point elements one word per beat over a valid/ready stream. Assembles A (4x4) and B (4x2), pulses start, and waits for done.
- Captures the 128-bit 4x2 product and re-serialises it as 8 words on a valid/ready output stream.
- Sits between the ZF detector's matrix sequencing logic and the multiplier datapath.

---
 rtl/zf_mm_stream_initiator.sv | 134 +++++++++++++
 tb/tb_zf_mm_stream_initiator.sv | 544 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zf_mm_stream_initiator.sv
// zf_mm_stream_initiator: collects a 24-word A/B frame, starts the 4x4-by-4x2
// multiplier, waits for done (with timeout) and streams the 8-word product out.
module zf_mm_stream_initiator #(
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [15:0]  in_data,
    input  logic         in_first,
    output logic         mm_start,
    output logic [255:0] mm_a,
    output logic [127:0] mm_b,
    input  logic         mm_done,
    input  logic [127:0] mm_result,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [15:0]  out_data,
    output logic         out_last,
    output logic         frame_err,
    output logic         timeout
);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_SEND  = 2'd3
    } state_t;

    localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);

    state_t       r_state;
    logic [4:0]   r_cnt;
    logic [7:0]   r_tcnt;
    logic [2:0]   r_idx;
    logic [255:0] r_a;
    logic [127:0] r_b;
    logic [127:0] r_buf;
    logic         r_frame_err;
    logic         r_timeout;

    logic         w_in_acc;
    logic         w_restart;
    logic [4:0]   w_slot;

    assign w_in_acc  = (r_state == S_LOAD) && in_valid;
    // A mid-frame in_first restarts the frame: the flagged word becomes word 0.
    assign w_restart = w_in_acc && in_first && (r_cnt != 5'd0);
    assign w_slot    = w_restart ? 5'd0 : r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_LOAD;
            r_cnt       <= 5'd0;
            r_tcnt      <= 8'd0;
            r_idx       <= 3'd0;
            r_a         <= '0;
            r_b         <= '0;
            r_buf       <= '0;
            r_frame_err <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            r_timeout   <= 1'b0;
            case (r_state)
                S_LOAD: begin
                    if (w_in_acc) begin
                        for (int k = 0; k < 16; k++) begin
                            if (w_slot == 5'(k)) r_a[255-16*k -: 16] <= in_data;
                        end
                        for (int k = 0; k < 8; k++) begin
                            if (w_slot == 5'(16 + k)) r_b[127-16*k -: 16] <= in_data;
                        end
                        r_frame_err <= w_restart;
                        if (w_slot == 5'd23) begin
                            r_cnt   <= 5'd0;
                            r_state <= S_START;
                        end else begin
                            r_cnt <= w_slot + 5'd1;
                        end
                    end
                end
                S_START: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (mm_done) begin
                        r_buf   <= mm_result;
                        r_tcnt  <= 8'd0;
                        r_idx   <= 3'd0;
                        r_state <= S_SEND;
                    end else if (r_tcnt == TMAX) begin
                        r_tcnt    <= 8'd0;
                        r_timeout <= 1'b1;
                        r_state   <= S_LOAD;
                    end else begin
                        r_tcnt <= r_tcnt + 8'd1;
                    end
                end
                S_SEND: begin
                    if (out_ready) begin
                        if (r_idx == 3'd7) begin
                            r_idx   <= 3'd0;
                            r_state <= S_LOAD;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

    // Word 0 of the product is the most significant slice of the buffer.
    always_comb begin
        out_data = 16'h0000;
        for (int k = 0; k < 8; k++) begin
            if (r_idx == 3'(k)) out_data = r_buf[127-16*k -: 16];
        end
    end

    assign in_ready  = (r_state == S_LOAD);
    assign mm_start  = (r_state == S_START);
    assign out_valid = (r_state == S_SEND);
    assign out_last  = (r_state == S_SEND) && (r_idx == 3'd7);
    assign mm_a      = r_a;
    assign mm_b      = r_b;
    assign frame_err = r_frame_err;
    assign timeout   = r_timeout;

endmodule

// File: tb/tb_zf_mm_stream_initiator.sv
// Self-checking bench for zf_mm_stream_initiator: a multiplier stub with 4-cycle
// done latency, random frames and results, checked against a frame/queue model.
module tb_zf_mm_stream_initiator;

    localparam int TIMEOUT = 16;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [15:0]  in_data = 16'h0;
    logic         in_first = 1'b0;
    logic         mm_start;
    logic [255:0] mm_a;
    logic [127:0] mm_b;
    logic         mm_done;
    logic [127:0] mm_result;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [15:0]  out_data;
    logic         out_last;
    logic         frame_err;
    logic         timeout;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    int startCount = 0;
    int lastStartCyc = -1;
    int timeoutCount = 0;
    int lastTimeoutCyc = -1;
    int feCount = 0;
    int validCount = 0;

    logic [3:0]   stubPipe = 4'b0;
    logic         stubEnable = 1'b1;
    logic         forceDone = 1'b0;
    logic [127:0] stubResult = '0;
    logic [127:0] forceResult = '0;

    logic [15:0] frame [24];
    logic [15:0] expWords [$];
    logic [15:0] gotWords [$];
    logic        gotLast [$];

    zf_mm_stream_initiator #(.TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_first  (in_first),
        .mm_start  (mm_start),
        .mm_a      (mm_a),
        .mm_b      (mm_b),
        .mm_done   (mm_done),
        .mm_result (mm_result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .frame_err (frame_err),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier stub: done four cycles after the start pulse, never reset.
    always @(posedge clk) stubPipe <= {stubPipe[2:0], mm_start};
    assign mm_done   = (stubPipe[3] && stubEnable) || forceDone;
    assign mm_result = forceDone ? forceResult : stubResult;

    always @(negedge clk) begin
        if (mm_start === 1'b1) begin
            startCount   <= startCount + 1;
            lastStartCyc <= cyc;
        end
        if (timeout === 1'b1) begin
            timeoutCount   <= timeoutCount + 1;
            lastTimeoutCyc <= cyc;
        end
        if (frame_err === 1'b1) feCount <= feCount + 1;
        if (out_valid === 1'b1) validCount <= validCount + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] model_a();
        logic [255:0] v = '0;
        for (int i = 0; i < 16; i++) v = {v[239:0], frame[i]};
        return v;
    endfunction

    function automatic logic [127:0] model_b();
        logic [127:0] v = '0;
        for (int i = 0; i < 8; i++) v = {v[111:0], frame[16+i]};
        return v;
    endfunction

    function automatic void build_expected(input logic [127:0] r);
        expWords.delete();
        for (int k = 0; k < 8; k++) begin
            expWords.push_back(r[127:112]);
            r = r << 16;
        end
    endfunction

    task automatic random_frame();
        for (int i = 0; i < 24; i++) frame[i] = 16'($urandom);
    endtask

    task automatic send_word(input logic [15:0] w, input logic f, output int accCyc, output bit ok);
        ok = 1'b0;
        accCyc = -1;
        if ($urandom_range(0, 3) == 0) tick();
        in_valid = 1'b1;
        in_data  = w;
        in_first = f;
        for (int g = 0; g < 64; g++) begin
            if (in_ready === 1'b1) begin
                accCyc = cyc;
                ok = 1'b1;
                tick();
                break;
            end
            tick();
        end
        in_valid = 1'b0;
        in_first = 1'b0;
    endtask

    task automatic load_frame(input bit firstFlag, output int lastCyc, output bit ok);
        bit okOne;
        ok = 1'b1;
        lastCyc = -1;
        for (int i = 0; i < 24; i++) begin
            send_word(frame[i], (i == 0) ? firstFlag : 1'b0, lastCyc, okOne);
            ok = ok && okOne;
        end
    endtask

    // mode 0: out_ready high, 1: toggling, 2: random. Runs until back in LOAD.
    task automatic drain(input int mode, input bit spurious, output int firstValid,
                         output int backCyc, output int stallErr);
        logic [15:0] heldData;
        logic        heldLast;
        bit          held;
        firstValid = -1;
        backCyc = -1;
        stallErr = 0;
        held = 1'b0;
        heldData = '0;
        heldLast = 1'b0;
        gotWords.delete();
        gotLast.delete();
        for (int c = 0; c < 200; c++) begin
            if (in_ready === 1'b1) begin
                backCyc = cyc;
                break;
            end
            if (out_valid === 1'b1) begin
                if (firstValid < 0) firstValid = cyc;
                if (held && (out_data !== heldData || out_last !== heldLast)) stallErr++;
            end
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ((c % 2) == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            forceDone   = spurious && (out_valid === 1'b1) && ($urandom_range(0, 1) == 1);
            forceResult = {$urandom, $urandom, $urandom, $urandom};
            if (out_valid === 1'b1 && out_ready) begin
                gotWords.push_back(out_data);
                gotLast.push_back(out_last);
                held = 1'b0;
            end else if (out_valid === 1'b1) begin
                held = 1'b1;
                heldData = out_data;
                heldLast = out_last;
            end
            tick();
        end
        out_ready = 1'b0;
        forceDone = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        compared++;
        if (in_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL reset_in_ready: got %b, expected 1", in_ready);
        end
        compared++;
        if ({mm_start, out_valid, out_last, frame_err, timeout} !== 5'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_flags: got %b, expected 00000",
                     {mm_start, out_valid, out_last, frame_err, timeout});
        end
        compared++;
        if (mm_a !== 256'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_mm_a: got %h, expected 0", mm_a);
        end
        compared++;
        if (mm_b !== 128'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_mm_b: got %h, expected 0", mm_b);
        end
        compared++;
        if (out_data !== 16'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_out_data: got %h, expected 0", out_data);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_identity();
        int t, fv, back, se, s0;
        bit ok;
        for (int i = 0; i < 16; i++) frame[i] = ((i % 5) == 0) ? 16'h0100 : 16'h0000;
        for (int k = 0; k < 8; k++) frame[16+k] = 16'(k + 1);
        stubResult = {$urandom, $urandom, $urandom, $urandom};
        build_expected(stubResult);
        s0 = startCount;
        load_frame(1'b1, t, ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("[TB] FAIL ident_load: frame not accepted within bound");
        end
        compared++;
        if (mm_a !== model_a()) begin
            mismatched++;
            $display("[TB] FAIL ident_mm_a: got %h, expected %h", mm_a, model_a());
        end
        compared++;
        if (mm_b !== model_b()) begin
            mismatched++;
            $display("[TB] FAIL ident_mm_b: got %h, expected %h", mm_b, model_b());
        end
        drain(0, 1'b0, fv, back, se);
        compared++;
        if (startCount != s0 + 1 || lastStartCyc != t + 1) begin
            mismatched++;
            $display("[TB] FAIL ident_start: got %0d pulses at cycle %0d, expected 1 at %0d",
                     startCount - s0, lastStartCyc, t + 1);
        end
        compared++;
        if (fv != t + 6) begin
            mismatched++;
            $display("[TB] FAIL ident_out_valid_cycle: got %0d, expected %0d", fv, t + 6);
        end
        compared++;
        if (back != t + 14) begin
            mismatched++;
            $display("[TB] FAIL ident_in_ready_back: got %0d, expected %0d", back, t + 14);
        end
        compared++;
        if (gotWords.size() != 8) begin
            mismatched++;
            $display("[TB] FAIL ident_word_count: got %0d, expected 8", gotWords.size());
        end
        foreach (gotWords[k]) begin
            if (k < 8) begin
                compared++;
                if (gotWords[k] !== expWords[k] || gotLast[k] !== (k == 7)) begin
                    mismatched++;
                    $display("[TB] FAIL ident_word%0d: got %h last=%b, expected %h last=%b",
                             k, gotWords[k], gotLast[k], expWords[k], (k == 7));
                end
            end
        end
    endtask

    task automatic test_stall();
        int t, fv, back, se;
        bit ok;
        random_frame();
        stubResult = {$urandom, $urandom, $urandom, $urandom};
        build_expected(stubResult);
        load_frame(1'b1, t, ok);
        drain(1, 1'b0, fv, back, se);
        compared++;
        if (!ok || back < 0) begin
            mismatched++;
            $display("[TB] FAIL stall_complete: load ok=%b back=%0d, expected ok=1 back>=0", ok, back);
        end
        compared++;
        if (se != 0) begin
            mismatched++;
            $display("[TB] FAIL stall_hold: got %0d changes while stalled, expected 0", se);
        end
        compared++;
        if (gotWords.size() != 8) begin
            mismatched++;
            $display("[TB] FAIL stall_word_count: got %0d, expected 8", gotWords.size());
        end
        foreach (gotWords[k]) begin
            if (k < 8) begin
                compared++;
                if (gotWords[k] !== expWords[k] || gotLast[k] !== (k == 7)) begin
                    mismatched++;
                    $display("[TB] FAIL stall_word%0d: got %h last=%b, expected %h last=%b",
                             k, gotWords[k], gotLast[k], expWords[k], (k == 7));
                end
            end
        end
    endtask

    task automatic test_frame_err();
        int t, fv, back, se, fe0, s0, dummy;
        bit ok, okOne;
        random_frame();
        stubResult = {$urandom, $urandom, $urandom, $urandom};
        build_expected(stubResult);
        fe0 = feCount;
        s0 = startCount;
        ok = 1'b1;
        for (int i = 0; i < 9; i++) begin
            send_word(16'($urandom), (i == 0), dummy, okOne);
            ok = ok && okOne;
        end
        for (int i = 0; i < 23; i++) begin
            send_word(frame[i], (i == 0), dummy, okOne);
            ok = ok && okOne;
        end
        compared++;
        if (in_ready !== 1'b1 || startCount != s0) begin
            mismatched++;
            $display("[TB] FAIL ferr_early_start: in_ready=%b starts=%0d, expected 1 and 0",
                     in_ready, startCount - s0);
        end
        send_word(frame[23], 1'b0, t, okOne);
        ok = ok && okOne;
        compared++;
        if (!ok || feCount != fe0 + 1) begin
            mismatched++;
            $display("[TB] FAIL ferr_pulse: load ok=%b pulses=%0d, expected ok=1 pulses=1",
                     ok, feCount - fe0);
        end
        compared++;
        if (mm_a[255:240] !== frame[0]) begin
            mismatched++;
            $display("[TB] FAIL ferr_a00: got %h, expected %h", mm_a[255:240], frame[0]);
        end
        compared++;
        if (mm_a !== model_a() || mm_b !== model_b()) begin
            mismatched++;
            $display("[TB] FAIL ferr_matrices: got a=%h b=%h, expected a=%h b=%h",
                     mm_a, mm_b, model_a(), model_b());
        end
        drain(0, 1'b0, fv, back, se);
        compared++;
        if (gotWords.size() != 8 || back != t + 14) begin
            mismatched++;
            $display("[TB] FAIL ferr_output: got %0d words back=%0d, expected 8 back=%0d",
                     gotWords.size(), back, t + 14);
        end
        foreach (gotWords[k]) begin
            if (k < 8) begin
                compared++;
                if (gotWords[k] !== expWords[k]) begin
                    mismatched++;
                    $display("[TB] FAIL ferr_word%0d: got %h, expected %h", k, gotWords[k], expWords[k]);
                end
            end
        end
    endtask

    task automatic test_timeout();
        int t, fv, back, se, t0, v0;
        bit ok;
        stubEnable = 1'b0;
        random_frame();
        t0 = timeoutCount;
        v0 = validCount;
        load_frame(1'b1, t, ok);
        drain(0, 1'b0, fv, back, se);
        tick();
        compared++;
        if (!ok || back != t + 2 + TIMEOUT) begin
            mismatched++;
            $display("[TB] FAIL tmo_back: load ok=%b back=%0d, expected ok=1 back=%0d",
                     ok, back, t + 2 + TIMEOUT);
        end
        compared++;
        if (timeoutCount != t0 + 1 || lastTimeoutCyc != t + 2 + TIMEOUT) begin
            mismatched++;
            $display("[TB] FAIL tmo_pulse: got %0d pulses at %0d, expected 1 at %0d",
                     timeoutCount - t0, lastTimeoutCyc, t + 2 + TIMEOUT);
        end
        compared++;
        if (validCount != v0 || fv != -1) begin
            mismatched++;
            $display("[TB] FAIL tmo_no_output: got %0d valid cycles, expected 0", validCount - v0);
        end
        compared++;
        if (in_ready !== 1'b1 || timeout !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL tmo_after: in_ready=%b timeout=%b, expected 1 and 0", in_ready, timeout);
        end
        stubEnable = 1'b1;
    endtask

    task automatic test_spurious();
        int t, fv, back, se, v0;
        bit ok;
        v0 = validCount;
        for (int i = 0; i < 4; i++) begin
            forceDone = 1'b1;
            forceResult = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        forceDone = 1'b0;
        tick();
        compared++;
        if (validCount != v0 || in_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL spur_load: valid cycles=%0d in_ready=%b, expected 0 and 1",
                     validCount - v0, in_ready);
        end
        random_frame();
        stubResult = {$urandom, $urandom, $urandom, $urandom};
        build_expected(stubResult);
        load_frame(1'b1, t, ok);
        drain(2, 1'b1, fv, back, se);
        compared++;
        if (!ok || gotWords.size() != 8 || se != 0) begin
            mismatched++;
            $display("[TB] FAIL spur_send: ok=%b words=%0d holdErr=%0d, expected 1, 8, 0",
                     ok, gotWords.size(), se);
        end
        foreach (gotWords[k]) begin
            if (k < 8) begin
                compared++;
                if (gotWords[k] !== expWords[k]) begin
                    mismatched++;
                    $display("[TB] FAIL spur_word%0d: got %h, expected %h", k, gotWords[k], expWords[k]);
                end
            end
        end
    endtask

    task automatic test_reset_wait();
        int t, v0, notReady;
        bit ok;
        random_frame();
        stubResult = {$urandom, $urandom, $urandom, $urandom};
        load_frame(1'b1, t, ok);
        tick();
        tick();
        reset_n = 1'b0;
        #2;
        compared++;
        if ({mm_start, out_valid, out_last, frame_err, timeout} !== 5'b0 || out_data !== 16'h0 ||
            in_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL rstw_outputs: flags=%b data=%h in_ready=%b, expected 00000 0000 1",
                     {mm_start, out_valid, out_last, frame_err, timeout}, out_data, in_ready);
        end
        compared++;
        if (mm_a !== 256'h0 || mm_b !== 128'h0) begin
            mismatched++;
            $display("[TB] FAIL rstw_matrices: a=%h b=%h, expected 0", mm_a, mm_b);
        end
        tick();
        reset_n = 1'b1;
        v0 = validCount;
        notReady = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (in_ready !== 1'b1) notReady++;
        end
        compared++;
        if (validCount != v0 || notReady != 0) begin
            mismatched++;
            $display("[TB] FAIL rstw_late_done: valid cycles=%0d not-ready cycles=%0d, expected 0 and 0",
                     validCount - v0, notReady);
        end
    endtask

    task automatic test_back_to_back();
        int t, fv, back, se;
        bit ok;
        for (int f = 0; f < 4; f++) begin
            random_frame();
            stubResult = {$urandom, $urandom, $urandom, $urandom};
            build_expected(stubResult);
            load_frame(1'($urandom_range(0, 1)), t, ok);
            compared++;
            if (!ok || mm_a !== model_a() || mm_b !== model_b()) begin
                mismatched++;
                $display("[TB] FAIL b2b%0d_load: ok=%b a=%h b=%h, expected a=%h b=%h",
                         f, ok, mm_a, mm_b, model_a(), model_b());
            end
            drain(2, 1'($urandom_range(0, 1)), fv, back, se);
            compared++;
            if (fv != t + 6 || back < 0 || gotWords.size() != 8 || se != 0) begin
                mismatched++;
                $display("[TB] FAIL b2b%0d_stream: first=%0d back=%0d words=%0d holdErr=%0d, expected first=%0d words=8",
                         f, fv, back, gotWords.size(), se, t + 6);
            end
            foreach (gotWords[k]) begin
                if (k < 8) begin
                    compared++;
                    if (gotWords[k] !== expWords[k] || gotLast[k] !== (k == 7)) begin
                        mismatched++;
                        $display("[TB] FAIL b2b%0d_word%0d: got %h last=%b, expected %h last=%b",
                                 f, k, gotWords[k], gotLast[k], expWords[k], (k == 7));
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_stall();
        test_frame_err();
        test_timeout();
        test_spurious();
        test_reset_wait();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
